// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: default widths, FSM state encoding and port ids.
package dmem_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_H = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select between CPU (C) and host (H) requests; combinational, zero latency.
// No backpressure of its own; a lone requester always wins.
// ARB_ROUND_ROBIN_EN defined: a tie goes to the port not in last_grant; undefined: C always beats H.
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic c_req,
    input  logic h_req,
    input  logic last_grant,
    output logic win
);

`ifdef ARB_ROUND_ROBIN_EN
    assign win = (c_req && h_req) ? ~last_grant : (h_req ? PORT_H : PORT_C);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign win = c_req ? PORT_C : PORT_H;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU (C) and host loader (H) ports.
// Latency: req sampled at N -> gnt/mem_en at N+1; reads -> rvalid with rdata at N+3.
// Backpressure: requester holds req until gnt; a losing port stays pending until the next IDLE. Tie policy set by ARB_ROUND_ROBIN_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    logic [1:0]        state;
    logic              cmd_port;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              last_grant;
    logic              win;

    dmem_arb_pick u_pick (
        .c_req      (c_req),
        .h_req      (h_req),
        .last_grant (last_grant),
        .win        (win)
    );

    // The whole command is captured at the IDLE decision so later input changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd_port   <= PORT_C;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            last_grant <= PORT_C;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (c_req || h_req) begin
                        cmd_port   <= win;
                        cmd_we     <= (win == PORT_H) ? h_we    : c_we;
                        cmd_addr   <= (win == PORT_H) ? h_addr  : c_addr;
                        cmd_wdata  <= (win == PORT_H) ? h_wdata : c_wdata;
                        last_grant <= win;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= cmd_we ? ST_IDLE : ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // RAM data lands in RESP; registering it here gives the fixed N+3 read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= '0;
            c_rvalid <= 1'b0;
            h_rvalid <= 1'b0;
        end else begin
            c_rvalid <= (state == ST_RESP) && (cmd_port == PORT_C);
            h_rvalid <= (state == ST_RESP) && (cmd_port == PORT_H);
            if (state == ST_RESP) begin
                rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state == ST_ISSUE);
    assign mem_we    = mem_en && cmd_we;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign c_gnt     = mem_en && (cmd_port == PORT_C);
    assign h_gnt     = mem_en && (cmd_port == PORT_H);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: RAM model, shadow-memory reference model and queue scoreboard.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int DW = 24;
    localparam int AW = 16;
    localparam bit P_C = 1'b0;
    localparam bit P_H = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, h_req, h_we;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_wdata, h_wdata;
    logic          c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Single-port RAM, one-cycle read latency
    logic [DW-1:0] ram [int];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
        end
    end

    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } rv_t;

    gnt_t          exp_gnt[$];
    rv_t           exp_rv[$];
    logic [DW-1:0] ref_mem [int];
    bit            m_last = P_C;
    int            checks = 0;
    int            errors = 0;
    int            last_rd_gnt = -100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: serve order decided by the priority rules, memory as a shadow array.
    function automatic bit tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return ~m_last;
`else
        return P_C;
`endif
    endfunction

    task automatic model_issue(input bit port, input bit we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input bit expect_rv);
        gnt_t g;
        rv_t  r;
        g = '{port: port, we: we, addr: a, wdata: d};
        exp_gnt.push_back(g);
        if (we) begin
            ref_mem[int'(a)] = d;
        end else if (expect_rv) begin
            r = '{port: port, data: (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0)};
            exp_rv.push_back(r);
        end
        m_last = port;
    endtask

    // Monitor: compares every grant and read response against the scoreboard queues
    gnt_t mg;
    rv_t  mr;
    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_en_vs_gnt", mem_en, c_gnt | h_gnt);
            if (c_gnt || h_gnt) begin
                chk("gnt_exclusive", c_gnt & h_gnt, 0);
                if (exp_gnt.size() == 0) begin
                    fail("gnt_unexpected", int'(h_gnt), -1);
                end else begin
                    mg = exp_gnt.pop_front();
                    chk("gnt_port", h_gnt, mg.port);
                    chk("mem_we", mem_we, mg.we);
                    chk("mem_addr", mem_addr, mg.addr);
                    if (mg.we) chk("mem_wdata", mem_wdata, mg.wdata);
                end
                if (!mem_we) last_rd_gnt = cyc;
            end
            if (c_rvalid || h_rvalid) begin
                chk("rvalid_exclusive", c_rvalid & h_rvalid, 0);
                chk("rvalid_latency", cyc, last_rd_gnt + 2);
                if (exp_rv.size() == 0) begin
                    fail("rvalid_unexpected", int'(h_rvalid), -1);
                end else begin
                    mr = exp_rv.pop_front();
                    chk("rvalid_port", h_rvalid, mr.port);
                    chk("rdata", rdata, mr.data);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_c_gnt"}, c_gnt, 0);
        chk({tag, "_h_gnt"}, h_gnt, 0);
        chk({tag, "_c_rvalid"}, c_rvalid, 0);
        chk({tag, "_h_rvalid"}, h_rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail("idle_timeout", n, 20);
    endtask

    // Drives one request from a port, waits for its grant and drops req; exp_lat counts negedges to gnt.
    task automatic serve(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int exp_lat, input bit chg, input logic [AW-1:0] a2);
        int n = 0;
        bit got = 1'b0;
        if (port) begin
            h_we = we; h_addr = a; h_wdata = d; h_req = 1'b1;
        end else begin
            c_we = we; c_addr = a; c_wdata = d; c_req = 1'b1;
        end
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = port ? h_gnt : c_gnt;
        end
        if (!got) fail("gnt_timeout", n, exp_lat);
        else chk("gnt_latency", n, exp_lat);
        if (chg) c_addr = a2;
        if (port) h_req = 1'b0;
        else c_req = 1'b0;
    endtask

    // mode 0: C only, 1: H only, 2: both ports in the same cycle
    task automatic round(input int mode,
                         input bit cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input bit hwe, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                         input bit chg, input logic [AW-1:0] ca2);
        bit w;
        wait_idle();
        if (mode == 0) begin
            model_issue(P_C, cwe, ca, cd, 1'b1);
            serve(P_C, cwe, ca, cd, 1, chg, ca2);
        end else if (mode == 1) begin
            model_issue(P_H, hwe, ha, hd, 1'b1);
            serve(P_H, hwe, ha, hd, 1, 1'b0, '0);
        end else begin
            w = tie_winner();
            if (w == P_C) begin
                model_issue(P_C, cwe, ca, cd, 1'b1);
                model_issue(P_H, hwe, ha, hd, 1'b1);
                fork
                    serve(P_C, cwe, ca, cd, 1, 1'b0, '0);
                    serve(P_H, hwe, ha, hd, cwe ? 3 : 4, 1'b0, '0);
                join
            end else begin
                model_issue(P_H, hwe, ha, hd, 1'b1);
                model_issue(P_C, cwe, ca, cd, 1'b1);
                fork
                    serve(P_H, hwe, ha, hd, 1, 1'b0, '0);
                    serve(P_C, cwe, ca, cd, hwe ? 3 : 4, 1'b0, '0);
                join
            end
        end
    endtask

    // Both ports hold read requests high across n_tx grants
    task automatic tie_stream(input logic [AW-1:0] ca, input logic [AW-1:0] ha, input int n_tx);
        bit w;
        int n;
        wait_idle();
        for (int i = 0; i < n_tx; i++) begin
            w = tie_winner();
            model_issue(w, 1'b0, w ? ha : ca, '0, 1'b1);
        end
        c_we = 1'b0; c_addr = ca; h_we = 1'b0; h_addr = ha;
        c_req = 1'b1; h_req = 1'b1;
        for (int i = 0; i < n_tx; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(c_gnt || h_gnt) && n < 40);
            if (!(c_gnt || h_gnt)) fail("tie_gnt_timeout", i, n_tx);
        end
        c_req = 1'b0; h_req = 1'b0;
    endtask

    task automatic reset_mid_read(input logic [AW-1:0] a);
        wait_idle();
        model_issue(P_C, 1'b0, a, '0, 1'b0);
        serve(P_C, 1'b0, a, '0, 1, 1'b0, '0);
        @(negedge clk);
        chk("rst_busy_in_resp", busy, 1);
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(negedge clk);
        check_zero("rst_held");
        rst = 1'b0;
        m_last = P_C;
        @(negedge clk);
        chk("rst_release_busy", busy, 0);
        chk("rst_release_c_rvalid", c_rvalid, 0);
        chk("rst_release_h_rvalid", h_rvalid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // CPU store then load
        round(0, 1'b1, 16'h0010, 24'h00ABCD, 1'b0, '0, '0, 1'b0, '0);
        round(0, 1'b0, 16'h0010, '0,         1'b0, '0, '0, 1'b0, '0);
        // Host preload then CPU read
        round(1, 1'b0, '0, '0, 1'b1, 16'h0020, 24'h123456, 1'b0, '0);
        round(0, 1'b0, 16'h0020, '0, 1'b0, '0, '0, 1'b0, '0);
        // Command fields frozen once issued
        round(1, 1'b0, '0, '0, 1'b1, 16'h0001, 24'h111111, 1'b0, '0);
        round(1, 1'b0, '0, '0, 1'b1, 16'h0002, 24'h222222, 1'b0, '0);
        round(0, 1'b0, 16'h0001, '0, 1'b0, '0, '0, 1'b1, 16'h0002);
        // Continuous tie with reads
        tie_stream(16'h0010, 16'h0020, 5);

        for (int i = 0; i < 60; i++) begin
            round(int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom()),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom()),
                  1'b0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        reset_mid_read(16'h0010);
        round(2, 1'b0, 16'h0020, '0, 1'b0, 16'h0001, '0, 1'b0, '0);
        tie_stream(16'h0002, 16'h0003, 4);

        repeat (10) @(negedge clk);
        chk("gnt_queue_drained", exp_gnt.size(), 0);
        chk("rvalid_queue_drained", exp_rv.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
